regfile_read_port: RTL and testbench
====================================

# regfile_read_port

Read side of the 32-entry register file: 32 x WIDTH storage written through the one-hot select vector produced by the 1-to-32 write decoder, plus two independent registered read ports addressed by 5-bit register numbers. Sits between the write-enable decoder and the datapath operand latches. Provides same-cycle write-to-read bypass, hard-wired zero register, and flags malformed write-select vectors.

## Interface
- WIDTH, 32, data width of each register and of read/write data
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- wrSel  input  32  one-hot write select from the write decoder; bit n selects register n; all-zero = no write
- wrData  input  WIDTH  data written to the selected register
- rdEnA  input  1  read request, port A
- rdRegA  input  5  register number, port A
- rdEnB  input  1  read request, port B
- rdRegB  input  5  register number, port B
- rdDataA  output  WIDTH  registered read data, port A
- rdValidA  output  1  one-cycle pulse: rdDataA updated by a read
- rdDataB  output  WIDTH  registered read data, port B
- rdValidB  output  1  one-cycle pulse: rdDataB updated by a read
- selErr  output  1  one-cycle pulse: previous wrSel was multi-hot

## Operation
- Reset (rst_n low, asynchronous): all 32 registers, rdDataA/B cleared to 0; rdValidA/B, selErr cleared to 0. Holding rst_n low blocks all writes and reads; first active edge after release is a normal cycle.
- Write: on rising edge, if wrSel has exactly one bit set at position n, n != 0, register n <= wrData.
- wrSel bit 0 alone: no write (register 0 is constant 0); not an error.
- wrSel all-zero: no write, no error.
- wrSel with two or more bits set: no register written; selErr = 1 for the following cycle.
- Read: on rising edge with rdEnX = 1, rdDataX <= contents of rdRegX, rdValidX <= 1. With rdEnX = 0, rdDataX holds its previous value and rdValidX <= 0.
- rdRegX = 0 always returns 0, regardless of wrSel.
- Bypass: if in the same cycle a legal write targets register n and rdRegX = n (n != 0), rdDataX captures wrData (new value), not the stored old value.
- Multi-hot write in same cycle as read: read returns stored (unchanged) value, no bypass.
- Ports A and B are fully independent; both may read the same register in the same cycle and return identical data.
- No backpressure: every accepted read completes; no request queueing.

## Timing
- Read latency: 1 cycle (address/enable sampled at edge k, rdData/rdValid valid after edge k, through edge k+1).
- Write visible to a non-bypassed read issued on the next edge (edge k+1).
- rdValidX: high exactly one cycle per accepted read; back-to-back reads keep it high continuously.
- selErr: registered, high for exactly the cycle after the offending edge; consecutive bad edges give a continuous high.
- rdData outputs are registered only; no combinational path from inputs to outputs.
- Reset assertion mid-read clears rdData/rdValid immediately (asynchronously), without waiting for a clock edge.

## Test plan
- Reset, then wrSel=32'h0000_0020, wrData=32'hDEAD_BEEF; next edge rdEnA=1, rdRegA=5 -> rdDataA=32'hDEAD_BEEF, rdValidA=1 for one cycle.
- Same edge: wrSel=32'h8000_0000, wrData=32'h1234_5678, rdEnB=1, rdRegB=31 -> rdDataB=32'h1234_5678 (bypass); then rdEnB=0 -> rdDataB holds, rdValidB=0.
- wrSel=32'h0000_0001, wrData=32'hFFFF_FFFF; rdRegA=0, rdRegB=0 both enabled -> both outputs 0, selErr=0.
- Reg 15 preloaded with 32'hA5A5_A5A5; wrSel=32'h0000_8002, wrData=32'h0 -> selErr=1 next cycle only; reads of regs 1 and 15 return 0 and 32'hA5A5_A5A5.
- Write regs 1, 5, 31; pull rst_n low between clock edges -> rdData/rdValid/selErr go 0 immediately; after release, reads of 1, 5, 31 return 0.
- Back-to-back rdEnA for regs 1, 5, 31 on three consecutive edges -> rdValidA high three consecutive cycles, data in issue order.

Source files
------------

// File: rtl/regfile_read_port_if.sv
// Bus bundle between the write decoder / read requesters and the register
// file read side. The master drives write select/data and read requests;
// the slave (register file) returns registered read data and status pulses.
interface regfile_read_port_if #(
   parameter int WIDTH = 32
);
   logic [31:0]      wrSel;
   logic [WIDTH-1:0] wrData;
   logic             rdEnA;
   logic [4:0]       rdRegA;
   logic             rdEnB;
   logic [4:0]       rdRegB;
   logic [WIDTH-1:0] rdDataA;
   logic             rdValidA;
   logic [WIDTH-1:0] rdDataB;
   logic             rdValidB;
   logic             selErr;

   modport master (
      output wrSel, wrData, rdEnA, rdRegA, rdEnB, rdRegB,
      input  rdDataA, rdValidA, rdDataB, rdValidB, selErr
   );

   modport slave (
      input  wrSel, wrData, rdEnA, rdRegA, rdEnB, rdRegB,
      output rdDataA, rdValidA, rdDataB, rdValidB, selErr
   );
endinterface

// File: rtl/regfile_read_port.sv
// 32-entry register file with one-hot write select and two independent
// registered read ports. Register 0 is hard-wired to zero, a legal write is
// bypassed to a same-cycle read of the same register, and multi-hot write
// selects are suppressed and flagged on selErr for one cycle.
module regfile_read_port #(
   parameter int WIDTH = 32
) (
   input logic                clk,
   input logic                rst_n,
   regfile_read_port_if.slave bus
);

   // Register 0 is never stored; entries 1..31 are real flops.
   logic [WIDTH-1:0] regs_q [1:31];
   logic [WIDTH-1:0] regs_d [1:31];

   logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
   logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
   logic             rd_valid_a_q, rd_valid_a_d;
   logic             rd_valid_b_q, rd_valid_b_d;
   logic             sel_err_q, sel_err_d;

   logic             sel_seen;
   logic             sel_multi;
   logic [4:0]       wr_idx;
   logic             wr_legal;

   // Value a read port captures: zero for r0, bypassed write data when a
   // legal write hits the same register this edge, else the stored value.
   function automatic logic [WIDTH-1:0] read_value(
      input logic [4:0]       rd_reg,
      input logic             legal,
      input logic [4:0]       widx,
      input logic [WIDTH-1:0] wdata,
      input logic [WIDTH-1:0] stored
   );
      logic [WIDTH-1:0] v;
      v = stored;
      if (rd_reg == 5'd0) begin
         v = '0;
      end else if (legal && (widx == rd_reg)) begin
         v = wdata;
      end
      return v;
   endfunction

   // Decode the write select: position of the set bit and whether more than one is set.
   always_comb begin
      sel_seen  = 1'b0;
      sel_multi = 1'b0;
      wr_idx    = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (bus.wrSel[i]) begin
            if (sel_seen) begin
               sel_multi = 1'b1;
            end
            sel_seen = 1'b1;
            wr_idx   = 5'(i);
         end
      end
      // A lone bit 0 targets the constant register, so it never writes.
      wr_legal = sel_seen && !sel_multi && (wr_idx != 5'd0);
   end

   // Next-state for storage, read ports and the select-error flag.
   always_comb begin
      for (int i = 1; i < 32; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_legal) begin
         regs_d[wr_idx] = bus.wrData;
      end

      rd_data_a_d  = rd_data_a_q;
      rd_data_b_d  = rd_data_b_q;
      rd_valid_a_d = bus.rdEnA;
      rd_valid_b_d = bus.rdEnB;
      if (bus.rdEnA) begin
         rd_data_a_d = read_value(bus.rdRegA, wr_legal, wr_idx, bus.wrData,
                                  (bus.rdRegA == 5'd0) ? '0 : regs_q[bus.rdRegA]);
      end
      if (bus.rdEnB) begin
         rd_data_b_d = read_value(bus.rdRegB, wr_legal, wr_idx, bus.wrData,
                                  (bus.rdRegB == 5'd0) ? '0 : regs_q[bus.rdRegB]);
      end

      sel_err_d = sel_multi;
   end

   // State registers; reset clears storage and outputs without a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         rd_data_a_q  <= '0;
         rd_data_b_q  <= '0;
         rd_valid_a_q <= 1'b0;
         rd_valid_b_q <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            regs_q[i] <= regs_d[i];
         end
         rd_data_a_q  <= rd_data_a_d;
         rd_data_b_q  <= rd_data_b_d;
         rd_valid_a_q <= rd_valid_a_d;
         rd_valid_b_q <= rd_valid_b_d;
         sel_err_q    <= sel_err_d;
      end
   end

   assign bus.rdDataA  = rd_data_a_q;
   assign bus.rdValidA = rd_valid_a_q;
   assign bus.rdDataB  = rd_data_b_q;
   assign bus.rdValidB = rd_valid_b_q;
   assign bus.selErr   = sel_err_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed and randomized bench for regfile_read_port. Expected outputs are
// computed from a reference model of the register file when each cycle's
// stimulus is driven, queued, and compared after the following clock edge.
module tb_regfile_read_port;

   localparam int WIDTH = 32;

   typedef struct {
      logic [WIDTH-1:0] data_a;
      logic             valid_a;
      logic [WIDTH-1:0] data_b;
      logic             valid_b;
      logic             sel_err;
   } exp_t;

   logic clk;
   logic rst_n;

   regfile_read_port_if #(.WIDTH(WIDTH)) bus ();

   regfile_read_port #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int               checks;
   int               errors;
   logic [WIDTH-1:0] model [32];
   logic [WIDTH-1:0] last_a;
   logic [WIDTH-1:0] last_b;
   exp_t             sb [$];

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model[i] = '0;
      last_a = '0;
      last_b = '0;
   endtask

   // Drive one cycle of stimulus, queue the expected result, clock, compare.
   task automatic cycle(input logic [31:0] sel, input logic [WIDTH-1:0] wd,
                        input logic ea, input logic [4:0] ra,
                        input logic eb, input logic [4:0] rb,
                        input string tag);
      int         cnt;
      int         widx;
      logic       legal;
      exp_t       e;
      exp_t       got;
      bus.wrSel  = sel;
      bus.wrData = wd;
      bus.rdEnA  = ea;
      bus.rdRegA = ra;
      bus.rdEnB  = eb;
      bus.rdRegB = rb;

      cnt  = 0;
      widx = 0;
      for (int i = 0; i < 32; i++) begin
         if (sel[i]) begin
            cnt++;
            widx = i;
         end
      end
      legal = (cnt == 1) && (widx != 0);

      e.valid_a = ea;
      e.valid_b = eb;
      e.sel_err = (cnt >= 2);
      if (!ea)                              e.data_a = last_a;
      else if (ra == 0)                     e.data_a = '0;
      else if (legal && widx == int'(ra))   e.data_a = wd;
      else                                  e.data_a = model[ra];
      if (!eb)                              e.data_b = last_b;
      else if (rb == 0)                     e.data_b = '0;
      else if (legal && widx == int'(rb))   e.data_b = wd;
      else                                  e.data_b = model[rb];
      last_a = e.data_a;
      last_b = e.data_b;
      if (legal) model[widx] = wd;
      sb.push_back(e);

      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({tag, ".rdDataA"},  bus.rdDataA, got.data_a);
      chk({tag, ".rdValidA"}, WIDTH'(bus.rdValidA), WIDTH'(got.valid_a));
      chk({tag, ".rdDataB"},  bus.rdDataB, got.data_b);
      chk({tag, ".rdValidB"}, WIDTH'(bus.rdValidB), WIDTH'(got.valid_b));
      chk({tag, ".selErr"},   WIDTH'(bus.selErr), WIDTH'(got.sel_err));
      $display("cycle %-10s sel=%h wd=%h A(%0d,%0d)=%h/%0b B(%0d,%0d)=%h/%0b err=%0b",
               tag, sel, wd, ea, ra, bus.rdDataA, bus.rdValidA,
               eb, rb, bus.rdDataB, bus.rdValidB, bus.selErr);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".rdDataA"},  bus.rdDataA, '0);
      chk({tag, ".rdValidA"}, WIDTH'(bus.rdValidA), '0);
      chk({tag, ".rdDataB"},  bus.rdDataB, '0);
      chk({tag, ".rdValidB"}, WIDTH'(bus.rdValidB), '0);
      chk({tag, ".selErr"},   WIDTH'(bus.selErr), '0);
      $display("check %-10s outputs all zero", tag);
   endtask

   initial begin
      logic [31:0] rsel;
      checks = 0;
      errors = 0;
      model_reset();
      rst_n      = 1'b0;
      bus.wrSel  = '0;
      bus.wrData = '0;
      bus.rdEnA  = 1'b0;
      bus.rdRegA = '0;
      bus.rdEnB  = 1'b0;
      bus.rdRegB = '0;

      // Reset held across edges: writes and reads blocked.
      #3;
      bus.wrSel  = 32'h0000_0004;
      bus.wrData = 32'h5555_5555;
      bus.rdEnA  = 1'b1;
      bus.rdRegA = 5'd2;
      #9;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Write then read port A.
      cycle(32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 5'd0,  1'b0, 5'd0,  "wr5");
      cycle(32'h0000_0000, 32'h0,         1'b1, 5'd5,  1'b0, 5'd0,  "rd5");
      // Bypass on port B, then hold.
      cycle(32'h8000_0000, 32'h1234_5678, 1'b0, 5'd0,  1'b1, 5'd31, "byp31");
      cycle(32'h0000_0000, 32'h0,         1'b0, 5'd0,  1'b0, 5'd0,  "holdB");
      // Reads of a register reset-blocked write: still zero.
      cycle(32'h0000_0000, 32'h0,         1'b1, 5'd2,  1'b1, 5'd31, "rd2");
      // Bit 0 alone: no write, no error; r0 reads zero.
      cycle(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 5'd0,  "r0");
      // Multi-hot write with reads of the targeted registers.
      cycle(32'h0000_8000, 32'hA5A5_A5A5, 1'b0, 5'd0,  1'b0, 5'd0,  "wr15");
      cycle(32'h0000_8002, 32'h0,         1'b1, 5'd1,  1'b1, 5'd15, "multi");
      cycle(32'h0000_0000, 32'h0,         1'b1, 5'd1,  1'b1, 5'd15, "after");
      // Consecutive bad edges keep selErr high.
      cycle(32'h0000_0003, 32'h1,         1'b0, 5'd0,  1'b0, 5'd0,  "bad1");
      cycle(32'hFFFF_FFFF, 32'h2,         1'b0, 5'd0,  1'b0, 5'd0,  "bad2");
      cycle(32'h0000_0000, 32'h0,         1'b1, 5'd15, 1'b0, 5'd0,  "bad_end");
      // Write regs 1,5,31; same-register read on both ports.
      cycle(32'h0000_0002, 32'h1111_1111, 1'b1, 5'd1,  1'b1, 5'd1,  "w1");
      cycle(32'h0000_0020, 32'h5555_0005, 1'b0, 5'd0,  1'b0, 5'd0,  "w5");
      cycle(32'h8000_0000, 32'h3131_3131, 1'b0, 5'd0,  1'b0, 5'd0,  "w31");
      // Back-to-back reads on port A.
      cycle(32'h0000_0000, 32'h0,         1'b1, 5'd1,  1'b0, 5'd0,  "b2b1");
      cycle(32'h0000_0000, 32'h0,         1'b1, 5'd5,  1'b0, 5'd0,  "b2b5");
      cycle(32'h0000_0000, 32'h0,         1'b1, 5'd31, 1'b1, 5'd5,  "b2b31");

      // Leave valids and selErr high, then reset between edges.
      cycle(32'h0000_0006, 32'h0,         1'b1, 5'd5,  1'b1, 5'd31, "prerst");
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      bus.wrSel = '0;
      bus.rdEnA = 1'b0;
      bus.rdEnB = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(32'h0000_0000, 32'h0,         1'b1, 5'd1,  1'b1, 5'd5,  "post1");
      cycle(32'h0000_0000, 32'h0,         1'b1, 5'd31, 1'b0, 5'd0,  "post31");

      // Randomized mix of legal, zero and multi-hot selects.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       rsel = 32'h0;
            1, 2:    rsel = 32'h1 << $urandom_range(0, 31);
            default: rsel = $urandom | 32'h0000_0101;
         endcase
         cycle(rsel, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
